// File: rtl/frogger_pkg.sv
// Shared types, geometry constants and position helpers for the frog player engine.
package frogger_pkg;

  typedef enum logic [1:0] {StIdle, StHop, StDead, StGameOver} frog_state_t;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_t;

  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;
  localparam int unsigned Tile    = 32;

  // Clamp a signed 11-bit candidate coordinate into [0, max].
  function automatic logic [9:0] clamp_pos(logic signed [10:0] v, logic [9:0] max);
    if (v < 0) begin
      return '0;
    end else if (v > $signed({1'b0, max})) begin
      return max;
    end else begin
      return v[9:0];
    end
  endfunction

  // Move pos at most px toward tgt without overshooting.
  function automatic logic [9:0] step_toward(logic [9:0] pos, logic [9:0] tgt, logic [9:0] px);
    if (tgt > pos) begin
      return ((tgt - pos) > px) ? pos + px : tgt;
    end else if (pos > tgt) begin
      return ((pos - tgt) > px) ? pos - px : tgt;
    end else begin
      return pos;
    end
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw asynchronous button plus a one-clock rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/frog_ctrl.sv
// Frog player-state engine: hop animation, death/respawn, lives and score, all
// advancing on frame_tick only so the renderer never sees a torn frame.
module frog_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned FROG_SIZE    = 32,
  parameter int unsigned STEP         = 32,
  parameter int unsigned HOP_PX       = 4,
  parameter int unsigned START_X      = 304,
  parameter int unsigned START_Y      = 448,
  parameter int unsigned MAX_X        = 608,
  parameter int unsigned MAX_Y        = 448,
  parameter int unsigned GOAL_Y       = 0,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [9:0] frog_size,
  output logic       hopping,
  output logic       dead,
  output logic       game_over,
  output logic [1:0] lives,
  output logic [7:0] score
);

  localparam logic [9:0]        StartX    = 10'(START_X);
  localparam logic [9:0]        StartY    = 10'(START_Y);
  localparam logic [9:0]        MaxX      = 10'(MAX_X);
  localparam logic [9:0]        MaxY      = 10'(MAX_Y);
  localparam logic [9:0]        GoalY     = 10'(GOAL_Y);
  localparam logic [9:0]        HopPx     = 10'(HOP_PX);
  localparam logic signed [10:0] Step     = 11'(STEP);
  localparam int unsigned       CntW      = $clog2(DEATH_FRAMES + 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(DEATH_FRAMES - 1);
  localparam logic [1:0]        LivesInit = 2'(LIVES);

  logic [3:0] btn_edge;
  logic       start_edge;

  btn_sync u_sync_up    (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),    .edge_o(btn_edge[0]));
  btn_sync u_sync_down  (.clk(clk), .rst_n(rst_n), .btn_i(btn_down),  .edge_o(btn_edge[1]));
  btn_sync u_sync_left  (.clk(clk), .rst_n(rst_n), .btn_i(btn_left),  .edge_o(btn_edge[2]));
  btn_sync u_sync_right (.clk(clk), .rst_n(rst_n), .btn_i(btn_right), .edge_o(btn_edge[3]));
  btn_sync u_sync_start (.clk(clk), .rst_n(rst_n), .btn_i(btn_start), .edge_o(start_edge));

  frog_state_t     state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [9:0]      tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      lives_q, lives_d;
  logic [7:0]      score_q, score_d;
  logic [3:0]      pend_q, pend_d;
  logic            start_pend_q, start_pend_d;

  // An edge landing on the tick cycle itself still counts for that tick.
  logic [3:0] pend_now;
  logic       start_now;
  assign pend_now  = pend_q | btn_edge;
  assign start_now = start_pend_q | start_edge;

  dir_t       dir;
  logic [9:0] tx, ty, mv_tx, mv_ty, nx, ny;
  logic       do_move;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    cnt_d        = cnt_q;
    lives_d      = lives_q;
    score_d      = score_q;
    pend_d       = frame_tick ? 4'b0000 : pend_now;
    start_pend_d = frame_tick ? 1'b0 : start_now;
    dir          = DirUp;
    tx           = x_q;
    ty           = y_q;
    mv_tx        = tgt_x_q;
    mv_ty        = tgt_y_q;
    nx           = x_q;
    ny           = y_q;
    do_move      = 1'b0;

    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            state_d = StDead;
            cnt_d   = '0;
          end else if (|pend_now) begin
            if (pend_now[0])      dir = DirUp;
            else if (pend_now[1]) dir = DirDown;
            else if (pend_now[2]) dir = DirLeft;
            else                  dir = DirRight;
            unique case (dir)
              DirUp:    ty = clamp_pos($signed({1'b0, y_q}) - Step, MaxY);
              DirDown:  ty = clamp_pos($signed({1'b0, y_q}) + Step, MaxY);
              DirLeft:  tx = clamp_pos($signed({1'b0, x_q}) - Step, MaxX);
              DirRight: tx = clamp_pos($signed({1'b0, x_q}) + Step, MaxX);
              default:  ;
            endcase
            // A clamped target equal to the current spot is a wall bump: no hop.
            if (tx != x_q || ty != y_q) begin
              do_move = 1'b1;
              mv_tx   = tx;
              mv_ty   = ty;
            end
          end
        end
        StHop: begin
          if (hit) begin
            state_d = StDead;
            cnt_d   = '0;
          end else begin
            do_move = 1'b1;
          end
        end
        StDead: begin
          if (cnt_q == CntLast) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = StGameOver;
            end else begin
              state_d = StIdle;
              x_d     = StartX;
              y_d     = StartY;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StGameOver: begin
          if (start_now) begin
            state_d = StIdle;
            lives_d = LivesInit;
            score_d = 8'd0;
            x_d     = StartX;
            y_d     = StartY;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (do_move) begin
      nx      = step_toward(x_q, mv_tx, HopPx);
      ny      = step_toward(y_q, mv_ty, HopPx);
      x_d     = nx;
      y_d     = ny;
      tgt_x_d = mv_tx;
      tgt_y_d = mv_ty;
      state_d = StHop;
      if (nx == mv_tx && ny == mv_ty) begin
        state_d = StIdle;
        if (ny == GoalY) begin
          if (score_q != 8'hff) score_d = score_q + 8'd1;
          x_d = StartX;
          y_d = StartY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x_q          <= StartX;
      y_q          <= StartY;
      tgt_x_q      <= StartX;
      tgt_y_q      <= StartY;
      cnt_q        <= '0;
      lives_q      <= LivesInit;
      score_q      <= 8'd0;
      pend_q       <= 4'b0000;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tgt_x_q      <= tgt_x_d;
      tgt_y_q      <= tgt_y_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      pend_q       <= pend_d;
      start_pend_q <= start_pend_d;
    end
  end

  assign frog_x    = x_q;
  assign frog_y    = y_q;
  assign frog_size = 10'(FROG_SIZE);
  assign hopping   = (state_q == StHop);
  assign dead      = (state_q == StDead);
  assign game_over = (state_q == StGameOver);
  assign lives     = lives_q;
  assign score     = score_q;

endmodule

// File: tb/tb_frog_ctrl.sv
// Scoreboard bench for frog_ctrl: a frame-level reference model predicts the outputs after
// every frame_tick; a separate monitor pops and compares them one clock after each tick.
module tb_frog_ctrl;

  localparam int FrameClks = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic       probe = 1'b0;
  logic [9:0] frog_x, frog_y, frog_size;
  logic       hopping, dead, game_over;
  logic [1:0] lives;
  logic [7:0] score;

  frog_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_start(btn_start), .frame_tick(frame_tick), .hit(hit),
    .frog_x(frog_x), .frog_y(frog_y), .frog_size(frog_size),
    .hopping(hopping), .dead(dead), .game_over(game_over), .lives(lives), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] size;
    logic       hop;
    logic       dead;
    logic       over;
    logic [1:0] lives;
    logic [7:0] score;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 hopping, 2 dead, 3 game over.
  int         m_x, m_y, m_tx, m_ty, m_lives, m_score, m_mode, m_dead_frames;
  logic [4:0] lvl_prev;

  function automatic int clampi(int v, int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  task automatic model_reset();
    m_x = 304; m_y = 448; m_tx = 304; m_ty = 448;
    m_lives = 3; m_score = 0; m_mode = 0; m_dead_frames = 0;
    lvl_prev = 5'b0;
  endtask

  task automatic model_advance();
    int dx = m_tx - m_x;
    int dy = m_ty - m_y;
    dx = (dx > 4) ? 4 : ((dx < -4) ? -4 : dx);
    dy = (dy > 4) ? 4 : ((dy < -4) ? -4 : dy);
    m_x += dx;
    m_y += dy;
    if (m_x == m_tx && m_y == m_ty) begin
      m_mode = 0;
      if (m_y == 0) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_x = 304; m_y = 448;
      end
    end
  endtask

  // presses: bit0 up, 1 down, 2 left, 3 right, 4 start (rising edges this frame)
  task automatic model_tick(input logic [4:0] presses, input logic h);
    int dx, dy;
    case (m_mode)
      0: begin
        if (h) begin
          m_mode = 2; m_dead_frames = 0;
        end else if (presses[3:0] != 4'b0) begin
          dx = 0; dy = 0;
          if (presses[0])      dy = -32;
          else if (presses[1]) dy = 32;
          else if (presses[2]) dx = -32;
          else                 dx = 32;
          m_tx = clampi(m_x + dx, 608);
          m_ty = clampi(m_y + dy, 448);
          if (m_tx != m_x || m_ty != m_y) begin
            m_mode = 1;
            model_advance();
          end
        end
      end
      1: begin
        if (h) begin
          m_mode = 2; m_dead_frames = 0;
        end else begin
          model_advance();
        end
      end
      2: begin
        m_dead_frames++;
        if (m_dead_frames == 60) begin
          m_lives--;
          if (m_lives == 0) begin
            m_mode = 3;
          end else begin
            m_mode = 0; m_x = 304; m_y = 448;
          end
        end
      end
      default: begin
        if (presses[4]) begin
          m_mode = 0; m_lives = 3; m_score = 0; m_x = 304; m_y = 448;
        end
      end
    endcase
  endtask

  task automatic push_exp();
    obs_t e;
    e.x     = 10'(m_x);
    e.y     = 10'(m_y);
    e.size  = 10'd32;
    e.hop   = (m_mode == 1);
    e.dead  = (m_mode == 2);
    e.over  = (m_mode == 3);
    e.lives = 2'(m_lives);
    e.score = 8'(m_score);
    exp_q.push_back(e);
  endtask

  // Monitor: checks outputs one clock after every frame_tick (or reset probe).
  initial begin
    logic tk;
    obs_t act, e;
    forever begin
      @(posedge clk);
      tk = frame_tick | probe;
      @(negedge clk);
      if (tk) begin
        checks++;
        act = {frog_x, frog_y, frog_size, hopping, dead, game_over, lives, score};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL obs#%0d no expected entry queued", checks);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL obs#%0d got x=%0d y=%0d sz=%0d hop=%b dead=%b over=%b lives=%0d score=%0d want x=%0d y=%0d sz=%0d hop=%b dead=%b over=%b lives=%0d score=%0d",
                     checks, act.x, act.y, act.size, act.hop, act.dead, act.over, act.lives,
                     act.score, e.x, e.y, e.size, e.hop, e.dead, e.over, e.lives, e.score);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    {btn_start, btn_right, btn_left, btn_down, btn_up} = 5'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    push_exp();
    probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  // One frame: set button levels, let them settle through the synchronizers, then tick.
  task automatic frame(input logic [4:0] lv, input logic h);
    logic [4:0] rise;
    @(negedge clk);
    {btn_start, btn_right, btn_left, btn_down, btn_up} = lv;
    rise = lv & ~lvl_prev;
    lvl_prev = lv;
    repeat (FrameClks - 2) begin
      @(negedge clk);
      hit = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    frame_tick = 1'b1;
    hit = h;
    model_tick(rise, h);
    push_exp();
    @(negedge clk);
    frame_tick = 1'b0;
    hit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) frame(5'b0, 1'b0);
  endtask

  task automatic hop_dir(input int d);
    frame(5'(1 << d), 1'b0);
    idle(8);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] lv;
    model_reset();
    do_reset();
    idle(10);
    // Single up hop, then a press during a hop, then a held button.
    frame(5'b00001, 1'b0); idle(7);
    frame(5'b00001, 1'b0); frame(5'b00100, 1'b0); idle(7);
    repeat (9) frame(5'b00001, 1'b0);
    idle(2);
    // Up and left in the same frame.
    frame(5'b00101, 1'b0); idle(8);
    // Right wall, then bottom wall.
    do_reset();
    repeat (12) hop_dir(3);
    hop_dir(1);
    // Hit on the third hopping tick, then two more deaths to game over, then restart.
    do_reset();
    frame(5'b00001, 1'b0); frame(5'b0, 1'b0); frame(5'b0, 1'b0); frame(5'b0, 1'b1);
    idle(62);
    repeat (2) begin
      frame(5'b0, 1'b1);
      idle(62);
    end
    idle(2);
    frame(5'b10000, 1'b0); idle(2);
    // Full crossing scores.
    repeat (14) hop_dir(0);
    // Hit on the tick that would reach the goal.
    do_reset();
    repeat (13) hop_dir(0);
    frame(5'b00001, 1'b0); idle(6); frame(5'b0, 1'b1);
    idle(62);
    // Reset mid-hop.
    frame(5'b00001, 1'b0); frame(5'b0, 1'b0);
    do_reset();
    idle(3);
    // Random play.
    repeat (600) begin
      for (int i = 0; i < 5; i++) lv[i] = ($urandom_range(0, 5) == 0);
      frame(lv, ($urandom_range(0, 39) == 0));
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never observed, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
